// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, opcodes and FSM encoding for the SPI master
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_SHIFT   = 3'd2;
  localparam state_t ST_WAIT    = 3'd3;
  localparam state_t ST_CAPTURE = 3'd4;
  localparam state_t ST_GAP     = 3'd5;

  // Slave select is asserted for every state that belongs to a frame on the wire.
  function automatic logic ss_active(input state_t st);
    return (st == ST_SELECT) || (st == ST_SHIFT) || (st == ST_WAIT) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host command/response bus plus SPI pins of the SPI master
interface spi_master_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [CMD_W-1:0]  cmd_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              seq_err;
  logic              busy;
  logic              SS_n;
  logic              MOSI;
  logic              MISO;

  modport master (
    input  cmd_valid, cmd_data, MISO,
    output cmd_ready, rsp_valid, rsp_data, seq_err, busy, SS_n, MOSI
  );

  modport slave (
    output cmd_valid, cmd_data, MISO,
    input  cmd_ready, rsp_valid, rsp_data, seq_err, busy, SS_n, MOSI
  );

endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI master serialising RAM commands and capturing read words
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_master_if.master bus
);

  localparam logic [3:0] SEL_LAST   = 4'd1;
  localparam logic [3:0] SHIFT_LAST = 4'(CMD_W - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_WAIT - 1);
  localparam logic [3:0] CAP_LAST   = 4'(DATA_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-2:0] sh_q, sh_d;
  logic              addr_loaded_q, addr_loaded_d;
  logic              ss_n_q, ss_n_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              seq_err_q, seq_err_d;

  // Next-state logic; outputs are derived from the next state so that the registered pins line up with the state they describe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 4'd1;
    cmd_d         = cmd_q;
    op_d          = op_q;
    sh_d          = sh_q;
    addr_loaded_d = addr_loaded_q;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data_q;
    seq_err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (bus.cmd_valid) begin
          state_d = ST_SELECT;
          cmd_d   = bus.cmd_data;
          op_d    = bus.cmd_data[CMD_W-1 -: 2];
          if (op_d == OP_RD_ADDR) addr_loaded_d = 1'b1;
          if (op_d == OP_RD_DATA && !addr_loaded_q) seq_err_d = 1'b1;
        end
      end
      ST_SELECT: begin
        if (cnt_q == SEL_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = 4'd0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          cnt_d = 4'd0;
          if (op_q == OP_RD_DATA) state_d = (RD_WAIT == 0) ? ST_CAPTURE : ST_WAIT;
          else                    state_d = ST_GAP;
        end else begin
          // MSB of cmd_q is always the bit on the wire; shift to expose the next one.
          cmd_d = cmd_q << 1;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = 4'd0;
        end
      end
      ST_CAPTURE: begin
        sh_d = {sh_q[DATA_W-3:0], bus.MISO};
        if (cnt_q == CAP_LAST) begin
          state_d       = ST_GAP;
          cnt_d         = 4'd0;
          rsp_data_d    = {sh_q, bus.MISO};
          rsp_valid_d   = 1'b1;
          addr_loaded_d = 1'b0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ss_n_d  = !ss_active(state_d);
    mosi_d  = (state_d == ST_SELECT || state_d == ST_SHIFT) ? cmd_d[CMD_W-1] : 1'b0;
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  // State and output registers with synchronous active-low reset; reset drops any partial capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      cmd_q         <= '0;
      op_q          <= 2'b00;
      sh_q          <= '0;
      addr_loaded_q <= 1'b0;
      ss_n_q        <= 1'b1;
      mosi_q        <= 1'b0;
      ready_q       <= 1'b1;
      busy_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      op_q          <= op_d;
      sh_q          <= sh_d;
      addr_loaded_q <= addr_loaded_d;
      ss_n_q        <= ss_n_d;
      mosi_q        <= mosi_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign bus.SS_n      = ss_n_q;
  assign bus.MOSI      = mosi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.seq_err   = seq_err_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;

  localparam int GAP_C = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_if bus0 ();
  spi_master_if bus1 ();

  spi_master #(.RD_WAIT(2), .GAP(GAP_C)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_master #(.RD_WAIT(4), .GAP(GAP_C)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int checks = 0;
  int errors = 0;

  int         rw [2]       = '{2, 4};
  logic [7:0] word [2]     = '{8'h00, 8'h00};
  logic       miso_r [2]   = '{1'b0, 1'b0};
  logic       ss_w [2], mosi_w [2], rdy_w [2], rv_w [2], se_w [2], busy_w [2];

  assign bus0.MISO = miso_r[0];
  assign bus1.MISO = miso_r[1];
  assign ss_w[0]   = bus0.SS_n;      assign ss_w[1]   = bus1.SS_n;
  assign mosi_w[0] = bus0.MOSI;      assign mosi_w[1] = bus1.MOSI;
  assign rdy_w[0]  = bus0.cmd_ready; assign rdy_w[1]  = bus1.cmd_ready;
  assign rv_w[0]   = bus0.rsp_valid; assign rv_w[1]   = bus1.rsp_valid;
  assign se_w[0]   = bus0.seq_err;   assign se_w[1]   = bus1.seq_err;
  assign busy_w[0] = bus0.busy;      assign busy_w[1] = bus1.busy;

  int          lowcnt [2]   = '{0, 0};
  int          highcnt [2]  = '{0, 0};
  int          last_low [2] = '{0, 0};
  int          rsp_cnt [2]  = '{0, 0};
  int          seq_cnt [2]  = '{0, 0};
  int          aligned [2]  = '{0, 0};
  logic        prev_ss [2]  = '{1'b1, 1'b1};
  logic [11:0] mosi_vec [2] = '{12'h0, 12'h0};
  int          frame_n = 0;
  logic [11:0] frame_log [32];
  int          high_log [32];

  // Slave model and bus monitor: counts SS_n-low edges, records MOSI, returns word on MISO.
  always @(negedge clk) begin
    int k;
    for (int i = 0; i < 2; i++) begin
      if (!ss_w[i]) begin
        if (prev_ss[i]) begin
          if (i == 0 && frame_n < 32) high_log[frame_n] = highcnt[0];
          lowcnt[i]   = 0;
          mosi_vec[i] = 12'h0;
        end
        lowcnt[i]++;
        if (lowcnt[i] <= 12) mosi_vec[i] = {mosi_vec[i][10:0], mosi_w[i]};
        k = lowcnt[i] - 12 - rw[i];
        if (k >= 1 && k <= 8) miso_r[i] = word[i][8-k];
        else                  miso_r[i] = 1'b0;
      end else begin
        if (!prev_ss[i]) begin
          last_low[i] = lowcnt[i];
          if (i == 0 && frame_n < 32) begin
            frame_log[frame_n] = mosi_vec[0];
            frame_n++;
          end
          highcnt[i] = 0;
        end
        highcnt[i]++;
        miso_r[i] = 1'b0;
      end
      if (rv_w[i]) begin
        rsp_cnt[i]++;
        if (ss_w[i] && !prev_ss[i]) aligned[i]++;
      end
      if (se_w[i]) seq_cnt[i]++;
      prev_ss[i] = ss_w[i];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int which, input logic v, input logic [9:0] d);
    if (which == 0) begin bus0.cmd_valid = v; bus0.cmd_data = d; end
    else            begin bus1.cmd_valid = v; bus1.cmd_data = d; end
  endtask

  task automatic wait_acc(input int which, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (rdy_w[which]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic issue(input int which, input logic [9:0] d, output int lat, output logic b1);
    bit ok;
    @(negedge clk);
    set_cmd(which, 1'b1, d);
    wait_acc(which, ok);
    check("accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    set_cmd(which, 1'b0, ~d);
    lat = 0;
    ok  = 1'b0;
    b1  = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      lat++;
      if (n == 0) b1 = busy_w[which];
      if (rdy_w[which]) begin ok = 1'b1; break; end
    end
    check("frame_done", 32'(ok), 32'd1);
  endtask

  function automatic logic [11:0] fv(input logic [9:0] c);
    return {c[9], c[9], c};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, r0, s0, a0, f0;
    logic b1;
    bit ok;
    logic [9:0] c [3];
    c = '{10'h011, 10'h122, 10'h233};

    set_cmd(0, 1'b0, 10'h0);
    set_cmd(1, 1'b0, 10'h0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ss_n",      32'(bus0.SS_n),      32'd1);
    check("rst_mosi",      32'(bus0.MOSI),      32'd0);
    check("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check("rst_busy",      32'(bus0.busy),      32'd0);
    check("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(bus0.rsp_data),  32'd0);
    check("rst_seq_err",   32'(bus0.seq_err),   32'd0);
    rst_n = 1'b1;

    // Write-address 0x05
    issue(0, 10'h005, lat, b1);
    check("wa_busy",     32'(b1),                    32'd1);
    check("wa_latency",  32'(lat),                   32'(12 + GAP_C + 1));
    check("wa_mosi",     32'(frame_log[frame_n-1]),  32'(fv(10'h005)));
    check("wa_ss_low",   32'(last_low[0]),           32'd12);
    check("wa_no_rsp",   32'(rsp_cnt[0]),            32'd0);
    check("wa_no_seq",   32'(seq_cnt[0]),            32'd0);

    // Read-address 0x05 then read-data returning 0xA5
    word[0] = 8'hA5;
    issue(0, 10'h205, lat, b1);
    check("ra_mosi", 32'(frame_log[frame_n-1]), 32'h0E05);
    r0 = rsp_cnt[0]; s0 = seq_cnt[0]; a0 = aligned[0];
    issue(0, 10'h300, lat, b1);
    check("rd_mosi",     32'(frame_log[frame_n-1]), 32'h0F00);
    check("rd_ss_low",   32'(last_low[0]),          32'(12 + 2 + 8));
    check("rd_latency",  32'(lat),                  32'(22 + GAP_C + 1));
    check("rd_data",     32'(bus0.rsp_data),        32'h00A5);
    check("rd_rsp_once", 32'(rsp_cnt[0] - r0),      32'd1);
    check("rd_rsp_edge", 32'(aligned[0] - a0),      32'd1);
    check("rd_no_seq",   32'(seq_cnt[0] - s0),      32'd0);

    // Read-data straight after reset, no read-address loaded
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    word[0] = 8'h5A;
    r0 = rsp_cnt[0]; s0 = seq_cnt[0];
    issue(0, 10'h300, lat, b1);
    check("seq_err_once", 32'(seq_cnt[0] - s0), 32'd1);
    check("seq_rsp_once", 32'(rsp_cnt[0] - r0), 32'd1);
    check("seq_rd_data",  32'(bus0.rsp_data),   32'h005A);
    check("seq_ss_low",   32'(last_low[0]),     32'd22);

    // Three commands with cmd_valid held high throughout
    f0 = frame_n;
    @(negedge clk);
    bus0.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.cmd_data = c[i];
      wait_acc(0, ok);
      check("b2b_accept", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    bus0.cmd_valid = 1'b0;
    wait_acc(0, ok);
    check("b2b_done",   32'(ok),            32'd1);
    check("b2b_frames", 32'(frame_n - f0),  32'd3);
    for (int i = 0; i < 3; i++) check("b2b_mosi", 32'(frame_log[f0+i]), 32'(fv(c[i])));
    // Each gap is the GAP state plus the single IDLE cycle in which the held command is accepted.
    check("b2b_gap1", 32'(high_log[f0+1]), 32'(GAP_C + 1));
    check("b2b_gap2", 32'(high_log[f0+2]), 32'(GAP_C + 1));

    // Reset landing on bit 6 of SHIFT of a read-data frame
    r0 = rsp_cnt[0];
    @(negedge clk);
    set_cmd(0, 1'b1, 10'h3FF);
    wait_acc(0, ok);
    check("mid_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    set_cmd(0, 1'b0, 10'h000);
    for (int n = 1; n <= 9; n++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_ss_n",      32'(bus0.SS_n),      32'd1);
    check("mid_mosi",      32'(bus0.MOSI),      32'd0);
    check("mid_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_no_rsp", 32'(rsp_cnt[0] - r0), 32'd0);

    // RD_WAIT=4 instance: capture window two cycles later
    word[1] = 8'h3C;
    issue(1, 10'h205, lat, b1);
    r0 = rsp_cnt[1];
    issue(1, 10'h300, lat, b1);
    check("rw4_data",    32'(bus1.rsp_data),   32'h003C);
    check("rw4_ss_low",  32'(last_low[1]),     32'(12 + 4 + 8));
    check("rw4_latency", 32'(lat),             32'(24 + GAP_C + 1));
    check("rw4_rsp",     32'(rsp_cnt[1] - r0), 32'd1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
